// File: rtl/rgmii_rx_framer.sv
// RGMII receive framer: strips preamble/SFD, emits payload bytes with sof/eof/err
// marks, enforces frame length limits and decodes in-band link status between frames.
module rgmii_rx_framer #(
  parameter int MAX_FRAME_LEN = 1522,
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_PREAMBLE  = 7
) (
  input  logic        rx_clk,
  input  logic        reset_n,
  input  logic [3:0]  dout_a,
  input  logic [3:0]  dout_b,
  input  logic        rx_ctl_a,
  input  logic        rx_ctl_b,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic        rx_err,
  output logic        link_up,
  output logic [1:0]  link_speed,
  output logic        link_duplex,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt,
  output logic [1:0]  state_dbg
);

  // rx_valid/rx_data: one-cycle pulse per payload byte, no ready; the consumer
  // must take every byte. rx_sof/rx_eof/rx_err are meaningful only with rx_valid.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2,
    S_DROP = 2'd3
  } state_t;

  localparam int          PRE_W   = $clog2(MAX_PREAMBLE + 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(MAX_PREAMBLE);
  localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_LEN);
  localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME_LEN);
  localparam logic [7:0]  PRE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE = 8'hD5;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic             sof_pend_q, sof_pend_d;
  logic             sticky_q, sticky_d;
  logic [10:0]      len_q, len_d;
  logic             arm_q, arm_d;

  logic [7:0]  data_d;
  logic        valid_d, sof_d, eof_d, err_d;
  logic        up_d, duplex_d;
  logic [1:0]  speed_d;
  logic        cnt_good, cnt_bad;

  logic [7:0] byte_in;
  logic       dv, er;

  assign byte_in   = {dout_b, dout_a};
  assign dv        = rx_ctl_a;
  assign er        = rx_ctl_a ^ rx_ctl_b;
  assign state_dbg = state_q;

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    sof_pend_d = sof_pend_q;
    sticky_d   = sticky_q;
    len_d      = len_q;
    // After reset a frame already in flight is ignored until the line goes idle.
    arm_d      = arm_q | ~dv;
    data_d     = rx_data;
    valid_d    = 1'b0;
    sof_d      = 1'b0;
    eof_d      = 1'b0;
    err_d      = 1'b0;
    up_d       = link_up;
    speed_d    = link_speed;
    duplex_d   = link_duplex;
    cnt_good   = 1'b0;
    cnt_bad    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (dv && arm_q) begin
          if (byte_in == PRE_BYTE) begin
            state_d   = S_PRE;
            pre_cnt_d = PRE_W'(1);
          end else if (byte_in == SFD_BYTE) begin
            state_d    = S_DATA;
            hold_vld_d = 1'b0;
            sof_pend_d = 1'b1;
            sticky_d   = 1'b0;
            len_d      = '0;
          end else begin
            state_d = S_DROP;
            cnt_bad = 1'b1;
          end
        end else if (!dv && !er && (dout_a == dout_b)) begin
          up_d     = byte_in[0];
          speed_d  = byte_in[2:1];
          duplex_d = byte_in[3];
        end
      end

      S_PRE: begin
        if (!dv) begin
          state_d = S_IDLE;
          cnt_bad = 1'b1;
        end else if (byte_in == SFD_BYTE) begin
          state_d    = S_DATA;
          hold_vld_d = 1'b0;
          sof_pend_d = 1'b1;
          sticky_d   = 1'b0;
          len_d      = '0;
        end else if ((byte_in == PRE_BYTE) && (pre_cnt_q < PRE_MAX)) begin
          pre_cnt_d = pre_cnt_q + 1'b1;
        end else begin
          state_d = S_DROP;
          cnt_bad = 1'b1;
        end
      end

      S_DATA: begin
        if (!dv) begin
          state_d    = S_IDLE;
          hold_vld_d = 1'b0;
          if (hold_vld_q) begin
            data_d   = hold_q;
            valid_d  = 1'b1;
            sof_d    = sof_pend_q;
            eof_d    = 1'b1;
            err_d    = sticky_q | (len_q < MIN_LEN);
            cnt_good = ~err_d;
            cnt_bad  = err_d;
          end else begin
            cnt_bad = 1'b1;
          end
        end else if (len_q == MAX_LEN) begin
          // Byte MAX_FRAME_LEN+1: close the frame on the held byte and discard the rest.
          state_d    = S_DROP;
          hold_vld_d = 1'b0;
          data_d     = hold_q;
          valid_d    = 1'b1;
          sof_d      = sof_pend_q;
          eof_d      = 1'b1;
          err_d      = 1'b1;
          cnt_bad    = 1'b1;
        end else begin
          if (hold_vld_q) begin
            data_d     = hold_q;
            valid_d    = 1'b1;
            sof_d      = sof_pend_q;
            sof_pend_d = 1'b0;
          end
          hold_d     = byte_in;
          hold_vld_d = 1'b1;
          len_d      = len_q + 11'd1;
          if (er) sticky_d = 1'b1;
        end
      end

      S_DROP: begin
        if (!dv) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      pre_cnt_q   <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      sof_pend_q  <= 1'b0;
      sticky_q    <= 1'b0;
      len_q       <= '0;
      arm_q       <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_sof      <= 1'b0;
      rx_eof      <= 1'b0;
      rx_err      <= 1'b0;
      link_up     <= 1'b0;
      link_speed  <= '0;
      link_duplex <= 1'b0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      sof_pend_q  <= sof_pend_d;
      sticky_q    <= sticky_d;
      len_q       <= len_d;
      arm_q       <= arm_d;
      rx_data     <= data_d;
      rx_valid    <= valid_d;
      rx_sof      <= sof_d;
      rx_eof      <= eof_d;
      rx_err      <= err_d;
      link_up     <= up_d;
      link_speed  <= speed_d;
      link_duplex <= duplex_d;
      if (cnt_good && (frame_cnt != 16'hFFFF)) frame_cnt <= frame_cnt + 16'd1;
      if (cnt_bad && (err_cnt != 16'hFFFF))   err_cnt   <= err_cnt + 16'd1;
    end
  end

endmodule
